x_format_ctrl: RTL

Multi-cycle controller that sequences one uPower X-format logical instruction at a time through the shared 64-bit register file and the external logical ALU. It accepts a 32-bit instruction over a valid/ready handshake and decodes PO/rs/ra/rb/XO/Rc. It reads rs and rb, drives the ALU, writes the result to ra and optionally updates CR0. It sits between instruction fetch and the X_Format datapath.

---
 rtl/x_format_pkg.sv | 27 ++
 rtl/x_format_decode.sv | 27 ++
 rtl/x_format_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/x_format_pkg.sv
// x_format_pkg: shared widths, opcodes, ALU op codes, FSM states and CR0 bit positions
package x_format_pkg;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam logic [5:0] PO_X = 6'd31;
  localparam logic [9:0] XO_AND  = 10'd28;
  localparam logic [9:0] XO_ANDC = 10'd60;
  localparam logic [9:0] XO_NOR  = 10'd124;
  localparam logic [9:0] XO_EQV  = 10'd284;
  localparam logic [9:0] XO_XOR  = 10'd316;
  localparam logic [9:0] XO_ORC  = 10'd412;
  localparam logic [9:0] XO_OR   = 10'd444;
  localparam logic [9:0] XO_NAND = 10'd476;
  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_ANDC = 4'd1;
  localparam logic [3:0] OP_NOR  = 4'd2;
  localparam logic [3:0] OP_EQV  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_ORC  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_NAND = 4'd7;
  localparam int CR0_LT = 3;
  localparam int CR0_GT = 2;
  localparam int CR0_EQ = 1;
  localparam int CR0_SO = 0;
  typedef enum logic [2:0] {IDLE, DECODE, READ, EXEC, WB, ERR} state_t;
endpackage

// File: rtl/x_format_decode.sv
// x_format_decode: maps primary/extended opcode to ALU op select and legality
module x_format_decode
  import x_format_pkg::*;
(
  input  logic [5:0] po,
  input  logic [9:0] xo,
  output logic [3:0] alu_op,
  output logic       legal
);
  logic hit;
  always_comb begin
    alu_op = OP_AND;
    hit = 1'b1;
    case (xo)
      XO_AND:  alu_op = OP_AND;
      XO_ANDC: alu_op = OP_ANDC;
      XO_NOR:  alu_op = OP_NOR;
      XO_EQV:  alu_op = OP_EQV;
      XO_XOR:  alu_op = OP_XOR;
      XO_ORC:  alu_op = OP_ORC;
      XO_OR:   alu_op = OP_OR;
      XO_NAND: alu_op = OP_NAND;
      default: hit = 1'b0;
    endcase
    legal = hit && po == PO_X;
  end
endmodule

// File: rtl/x_format_ctrl.sv
// x_format_ctrl: sequences one X-format logical instruction through register file and ALU.
// Define X_CTRL_PERF_EN to add perf_retired/perf_illegal counters.
module x_format_ctrl
  import x_format_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_rd_addr_a,
  output logic [ADDR_W-1:0] rf_rd_addr_b,
  input  logic [DATA_W-1:0] rf_rd_data_a,
  input  logic [DATA_W-1:0] rf_rd_data_b,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  input  logic              xer_so,
  output logic              cr0_wr_en,
  output logic [3:0]        cr0,
  output logic              done,
  output logic              illegal
`ifdef X_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_illegal
`endif
);
  state_t state, state_nx;
  logic [31:0] instr_q;
  logic [DATA_W-1:0] a_q, b_q, res_q;
  logic [3:0] op_q, dec_op, cr0_q, cr0_nx;
  logic [ADDR_W-1:0] rs, ra, rb;
  logic legal, rc;
  assign {rs, ra, rb} = instr_q[25:11];
  assign rc = instr_q[0];
  x_format_decode u_dec (.po(instr_q[31:26]), .xo(instr_q[10:1]), .alu_op(dec_op), .legal(legal));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      instr_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      op_q <= '0;
      cr0_q <= '0;
    end else begin
      state <= state_nx;
      if (instr_ready && instr_valid) instr_q <= instr;
      if (state == READ) op_q <= dec_op;
      if (state == EXEC) begin
        a_q <= rf_rd_data_a;
        b_q <= rf_rd_data_b;
        res_q <= alu_result;
      end
      if (cr0_wr_en) cr0_q <= cr0_nx;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = instr_valid ? DECODE : IDLE;
      DECODE:  state_nx = legal ? READ : ERR;
      READ:    state_nx = EXEC;
      EXEC:    state_nx = WB;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    cr0_nx = '0;
    cr0_nx[CR0_LT] = res_q[DATA_W-1];
    cr0_nx[CR0_GT] = ~res_q[DATA_W-1] & |res_q;
    cr0_nx[CR0_EQ] = ~|res_q;
    cr0_nx[CR0_SO] = xer_so;
  end
  // Operands come straight from the RF during EXEC and are held afterwards
  assign alu_a = state == EXEC ? rf_rd_data_a : a_q;
  assign alu_b = state == EXEC ? rf_rd_data_b : b_q;
  assign alu_op = op_q;
  assign instr_ready = state == IDLE;
  assign rf_rd_en = state == READ;
  assign rf_rd_addr_a = rf_rd_en ? rs : '0;
  assign rf_rd_addr_b = rf_rd_en ? rb : '0;
  assign rf_wr_en = state == WB;
  assign rf_wr_addr = rf_wr_en ? ra : '0;
  assign rf_wr_data = rf_wr_en ? res_q : '0;
  assign done = rf_wr_en;
  assign cr0_wr_en = rf_wr_en & rc;
  assign cr0 = cr0_wr_en ? cr0_nx : cr0_q;
  assign illegal = state == ERR;
`ifdef X_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_retired <= '0;
      perf_illegal <= '0;
    end else begin
      perf_retired <= perf_retired + {31'd0, done};
      perf_illegal <= perf_illegal + {31'd0, illegal};
    end
  end
`endif
endmodule
